// File: rtl/decode_writeback_if.sv
`default_nettype none
// ============================================================================
// Module  : decode_writeback_if
// Purpose : Fetch/execute-side bundle into the Y86-64 decode/write-back stage.
// Revision: 1.0
// ============================================================================
interface decode_writeback_if #(
  parameter int DATA_W = 64
);
  logic              instr_valid;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic              cnd;
  logic              wb_en;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valM;
  logic [3:0]        srcA;
  logic [3:0]        srcB;
  logic [3:0]        dstE;
  logic [3:0]        dstM;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;

  modport master (
    output instr_valid, icode, ifun, rA, rB, cnd, wb_en, valE, valM,
    input  srcA, srcB, dstE, dstM, valA, valB
  );

  modport slave (
    input  instr_valid, icode, ifun, rA, rB, cnd, wb_en, valE, valM,
    output srcA, srcB, dstE, dstM, valA, valB
  );
endinterface
`default_nettype wire

// File: rtl/decode_writeback.sv
`default_nettype none
// ============================================================================
// Module  : decode_writeback
// Purpose : SEQ Y86-64 decode (index derivation, register reads) and write-back.
// Revision: 1.0
// ============================================================================
module decode_writeback #(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input  wire                clk,
  input  wire                rst_n,
  decode_writeback_if.slave  bus
);
  localparam logic [3:0] c_RSP  = 4'h4;
  localparam logic [3:0] c_NONE = 4'hF;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_COMMIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_regs [0:14];
  logic [3:0]        w_srcA, w_srcB, w_dstE, w_dstM;
  logic [DATA_W-1:0] w_valA, w_valB;

  always_comb begin
    w_srcA = c_NONE;
    w_srcB = c_NONE;
    w_dstE = c_NONE;
    w_dstM = c_NONE;
    if (bus.instr_valid) begin
      case (bus.icode)
        4'h2, 4'h4, 4'h6, 4'hA: w_srcA = bus.rA;
        4'h9, 4'hB:             w_srcA = c_RSP;
        default:                w_srcA = c_NONE;
      endcase
      case (bus.icode)
        4'h4, 4'h5, 4'h6:       w_srcB = bus.rB;
        4'h8, 4'h9, 4'hA, 4'hB: w_srcB = c_RSP;
        default:                w_srcB = c_NONE;
      endcase
      // rrmovq (ifun 0) shares icode 2 with the cmovXX family but never gates.
      case (bus.icode)
        4'h2:                   w_dstE = (bus.cnd || bus.ifun == 4'h0) ? bus.rB : c_NONE;
        4'h3, 4'h6:             w_dstE = bus.rB;
        4'h8, 4'h9, 4'hA, 4'hB: w_dstE = c_RSP;
        default:                w_dstE = c_NONE;
      endcase
      case (bus.icode)
        4'h5, 4'hB:             w_dstM = bus.rA;
        default:                w_dstM = c_NONE;
      endcase
    end
  end

  always_comb begin
    w_valA = '0;
    w_valB = '0;
    for (int i = 0; i < 15; i++) begin
      if (w_srcA == 4'(i)) w_valA = r_regs[i];
      if (w_srcB == 4'(i)) w_valB = r_regs[i];
    end
  end

  // The M port is checked first so popq %rsp keeps the popped value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= (i == 4) ? RSP_INIT : '0;
      end
    end else if (bus.wb_en) begin
      for (int i = 0; i < 15; i++) begin
        if (w_dstM == 4'(i))      r_regs[i] <= bus.valM;
        else if (w_dstE == 4'(i)) r_regs[i] <= bus.valE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:   if (bus.wb_en && (w_dstE != c_NONE || w_dstM != c_NONE)) w_state_nxt = S_COMMIT;
      S_COMMIT: if (bus.wb_en) w_state_nxt = S_COMMIT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.srcA = w_srcA;
  assign bus.srcB = w_srcB;
  assign bus.dstE = w_dstE;
  assign bus.dstM = w_dstM;
  assign bus.valA = w_valA;
  assign bus.valB = w_valB;
endmodule
`default_nettype wire

// File: tb/tb_decode_writeback.sv
`default_nettype none
// ============================================================================
// Module  : tb_decode_writeback
// Purpose : Directed + randomized bench for decode_writeback against a register-file model.
// Revision: 1.0
// ============================================================================
module tb_decode_writeback;
  localparam int          DW   = 64;
  localparam logic [63:0] RSP0 = 64'h200;
  localparam logic [3:0]  NONE = 4'hF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [63:0] m_regs [0:14];

  decode_writeback_if #(.DATA_W(DW)) bus ();
  decode_writeback #(.DATA_W(DW), .RSP_INIT(RSP0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_srcA();
    if (!bus.instr_valid) return NONE;
    if (bus.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) return bus.rA;
    if (bus.icode inside {4'h9, 4'hB}) return 4'h4;
    return NONE;
  endfunction

  function automatic logic [3:0] m_srcB();
    if (!bus.instr_valid) return NONE;
    if (bus.icode inside {4'h4, 4'h5, 4'h6}) return bus.rB;
    if (bus.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return NONE;
  endfunction

  function automatic logic [3:0] m_dstE();
    if (!bus.instr_valid) return NONE;
    if (bus.icode == 4'h2) return (bus.cnd || bus.ifun == 4'h0) ? bus.rB : NONE;
    if (bus.icode inside {4'h3, 4'h6}) return bus.rB;
    if (bus.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return NONE;
  endfunction

  function automatic logic [3:0] m_dstM();
    if (!bus.instr_valid) return NONE;
    if (bus.icode inside {4'h5, 4'hB}) return bus.rA;
    return NONE;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] idx);
    return (idx == NONE) ? 64'h0 : m_regs[idx];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? RSP0 : 64'h0;
  endtask

  task automatic set_in(input logic iv, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb, input logic c,
                        input logic wb, input logic [63:0] ve, input logic [63:0] vm);
    @(negedge clk);
    bus.instr_valid = iv; bus.icode = ic; bus.ifun = fn; bus.rA = ra; bus.rB = rb;
    bus.cnd = c; bus.wb_en = wb; bus.valE = ve; bus.valM = vm;
    #1;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".srcA"}, 64'(bus.srcA), 64'(m_srcA()));
    check_val({tag, ".srcB"}, 64'(bus.srcB), 64'(m_srcB()));
    check_val({tag, ".dstE"}, 64'(bus.dstE), 64'(m_dstE()));
    check_val({tag, ".dstM"}, 64'(bus.dstM), 64'(m_dstM()));
    check_val({tag, ".valA"}, bus.valA, m_read(m_srcA()));
    check_val({tag, ".valB"}, bus.valB, m_read(m_srcB()));
  endtask

  // Rising edge: the model commits what the decoded instruction says, M after E.
  task automatic tick();
    logic [3:0] e, m;
    e = m_dstE();
    m = m_dstM();
    @(posedge clk);
    if (rst_n && bus.wb_en) begin
      if (e != NONE) m_regs[e] = bus.valE;
      if (m != NONE) m_regs[m] = bus.valM;
    end
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 15; i++) begin
      set_in(1'b1, 4'h2, 4'h0, 4'(i), NONE, 1'b0, 1'b0, 64'h0, 64'h0);
      check_val({tag, ".reg"}, bus.valA, m_regs[i]);
    end
  endtask

  initial begin
    m_reset();
    bus.instr_valid = 1'b0; bus.icode = 4'h0; bus.ifun = 4'h0; bus.rA = NONE; bus.rB = NONE;
    bus.cnd = 1'b0; bus.wb_en = 1'b0; bus.valE = '0; bus.valM = '0;

    // Reset contents: popq reads %rsp = RSP_INIT, everything else zero.
    set_in(1'b1, 4'hB, 4'h0, 4'h1, NONE, 1'b0, 1'b0, 64'h0, 64'h0);
    check_val("rst.popq.valA", bus.valA, 64'h200);
    check_all("rst.popq");
    sweep("rst");
    @(negedge clk); rst_n = 1'b1;

    // irmovq to reg 2, read back with rrmovq.
    set_in(1'b1, 4'h3, 4'h0, NONE, 4'h2, 1'b0, 1'b1, 64'h1234, 64'h0);
    check_val("irmovq.dstE", 64'(bus.dstE), 64'h2);
    tick();
    set_in(1'b1, 4'h2, 4'h0, 4'h2, NONE, 1'b0, 1'b0, 64'h0, 64'h0);
    check_val("irmovq.readback", bus.valA, 64'h1234);

    // cmovle: cnd=0 suppresses, cnd=1 writes.
    set_in(1'b1, 4'h2, 4'h1, 4'h1, 4'h3, 1'b0, 1'b1, 64'h5, 64'h0);
    check_val("cmov.nc.dstE", 64'(bus.dstE), 64'hF);
    tick();
    check_val("cmov.nc.reg3", m_regs[3], 64'h0);
    set_in(1'b1, 4'h2, 4'h1, 4'h1, 4'h3, 1'b1, 1'b1, 64'h5, 64'h0);
    check_val("cmov.c.dstE", 64'(bus.dstE), 64'h3);
    tick();
    sweep("cmov");

    // popq %rsp: M write wins.
    set_in(1'b1, 4'hB, 4'h0, 4'h4, NONE, 1'b0, 1'b1, 64'h208, 64'hABC);
    check_val("popq_rsp.dstE", 64'(bus.dstE), 64'h4);
    check_val("popq_rsp.dstM", 64'(bus.dstM), 64'h4);
    tick();
    set_in(1'b1, 4'hB, 4'h0, 4'h0, NONE, 1'b0, 1'b0, 64'h0, 64'h0);
    check_val("popq_rsp.reg4", bus.valA, 64'hABC);

    // Same-cycle read/write of reg 7: old before the edge, new after.
    set_in(1'b1, 4'h3, 4'h0, NONE, 4'h7, 1'b0, 1'b1, 64'h77, 64'h0);
    tick();
    set_in(1'b1, 4'h2, 4'h0, 4'h7, 4'h7, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0007, 64'h0);
    check_val("rw7.before", bus.valA, 64'h77);
    tick();
    check_val("rw7.after", bus.valA, 64'hDEAD_BEEF_0000_0007);

    // nop with wb_en=1 touches nothing.
    set_in(1'b1, 4'h1, 4'h0, 4'h2, 4'h5, 1'b1, 1'b1, 64'hFFFF, 64'hEEEE);
    check_all("nop");
    tick();
    sweep("nop");

    // Asynchronous reset mid-cycle while a write is pending.
    set_in(1'b1, 4'h2, 4'h0, 4'h2, 4'h2, 1'b0, 1'b1, 64'h99, 64'h0);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    check_val("arst.immediate", bus.valA, 64'h0);
    tick();
    check_val("arst.nowrite", bus.valA, 64'h0);
    set_in(1'b0, 4'hB, 4'h0, 4'h2, 4'h3, 1'b1, 1'b1, 64'h1, 64'h2);
    check_all("arst.invalid");
    sweep("arst");
    @(negedge clk); rst_n = 1'b1;
    set_in(1'b1, 4'h3, 4'h0, NONE, 4'h9, 1'b0, 1'b1, 64'h4242, 64'h0);
    tick();
    sweep("post_rst");

    // Randomized instruction stream.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] ic;
      ic = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 11));
      set_in(($urandom_range(0, 9) != 0), ic, 4'($urandom_range(0, 6)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
             {$urandom, $urandom}, {$urandom, $urandom});
      check_all("rand");
      tick();
    end
    sweep("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
